// File: rtl/esdi_pkg.sv
// Shared types for the ESDI serial command/status engine.
// State encoding, completion codes and frame length.
package esdi_pkg;

  localparam int CMD_BITS = 17;

  typedef enum logic [3:0] {
    S_IDLE,
    S_TX_SETUP,
    S_TX_WAIT_ACK,
    S_TX_HOLD,
    S_TX_WAIT_NACK,
    S_RX_WAIT_ACK,
    S_RX_HOLD,
    S_RX_WAIT_NACK,
    S_RX_STALL,
    S_WAIT_CMPL,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_PARITY  = 2'd2
  } done_st_t;

endpackage

// File: rtl/esdi_sync2.sv
// Two-flop synchronizer for asynchronous drive-side inputs.
// Clears to 0 on asynchronous active-low reset.
module esdi_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/esdi_serial_cmd_engine.sv
// Bit-serial ESDI command/status engine: shifts a command out over
// TRANSFER REQ/ACK, reads back status words, reports completion.
module esdi_serial_cmd_engine
  import esdi_pkg::*;
#(
  parameter int DATA_SETUP  = 6,
  parameter int ACK_TO_NREQ = 6,
  parameter int BIT_TIMEOUT = 1_000_000
) (
  input  logic        csr_aclk,
  input  logic        csr_aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_word,
  input  logic [1:0]  cmd_resp_words,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_word,
  output logic        rsp_parity_err,
  output logic        done_valid,
  output logic [1:0]  done_status,
  output logic        esdi_transfer_req,
  output logic        esdi_command_data,
  input  logic        esdi_transfer_ack,
  input  logic        esdi_confstat_data,
  input  logic        esdi_command_complete
);

  localparam int CMAX = (DATA_SETUP > ACK_TO_NREQ) ?
                        DATA_SETUP : ACK_TO_NREQ;
  localparam int CW = $clog2(CMAX) + 1;
  localparam int TW = $clog2(BIT_TIMEOUT) + 1;

  localparam logic [CW-1:0] SETUP_END = CW'(DATA_SETUP - 1);
  localparam logic [CW-1:0] HOLD_END  = CW'(ACK_TO_NREQ - 1);
  localparam logic [TW-1:0] TMO_END   = TW'(BIT_TIMEOUT - 1);
  localparam logic [4:0]    LAST_BIT  = 5'(CMD_BITS - 1);

  logic ack_s;
  logic dat_s;
  logic cmpl_s;

  esdi_sync2 u_sync_ack (
    .clk   (csr_aclk),
    .rst_n (csr_aresetn),
    .d     (esdi_transfer_ack),
    .q     (ack_s)
  );

  esdi_sync2 u_sync_dat (
    .clk   (csr_aclk),
    .rst_n (csr_aresetn),
    .d     (esdi_confstat_data),
    .q     (dat_s)
  );

  esdi_sync2 u_sync_cmpl (
    .clk   (csr_aclk),
    .rst_n (csr_aresetn),
    .d     (esdi_command_complete),
    .q     (cmpl_s)
  );

  state_t        state_q;
  state_t        state_n;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tmo_q;
  logic [16:0]   tx_sh;
  logic [16:0]   rx_sh;
  logic [4:0]    bit_q;
  logic [1:0]    words_q;
  logic          perr_q;
  logic [1:0]    done_q;

  logic last_bit;
  logic tmo_end;
  logic tmo_hit;
  logic rx_go;
  logic wait_st;
  logic tx_st;
  logic rx_req;
  logic accept;
  logic tx_shift;
  logic rx_samp;
  logic rx_step;
  logic rx_done;

  assign last_bit = (bit_q == LAST_BIT);
  assign tmo_end  = (tmo_q == TMO_END);
  assign rx_go    = !(rsp_valid && !rsp_ready);

  assign wait_st = (state_q == S_TX_WAIT_ACK)  ||
                   (state_q == S_TX_WAIT_NACK) ||
                   (state_q == S_RX_WAIT_ACK)  ||
                   (state_q == S_RX_WAIT_NACK) ||
                   (state_q == S_WAIT_CMPL);

  assign tx_st = (state_q == S_TX_SETUP)    ||
                 (state_q == S_TX_WAIT_ACK) ||
                 (state_q == S_TX_HOLD)     ||
                 (state_q == S_TX_WAIT_NACK);

  assign rx_req = (state_q == S_RX_WAIT_ACK) ||
                  (state_q == S_RX_HOLD);

  assign accept   = (state_q == S_IDLE) && cmd_valid;
  assign tx_shift = (state_q == S_TX_WAIT_NACK) && !ack_s;
  assign rx_samp  = (state_q == S_RX_WAIT_ACK) && ack_s;
  assign rx_step  = (state_q == S_RX_WAIT_NACK) && !ack_s;
  assign rx_done  = rx_step && last_bit;

  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    tmo_hit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) state_n = S_TX_SETUP;
      end
      S_TX_SETUP: begin
        if (cnt_q == SETUP_END) state_n = S_TX_WAIT_ACK;
      end
      S_TX_WAIT_ACK: begin
        if (ack_s) begin
          state_n = S_TX_HOLD;
        end else if (tmo_end) begin
          state_n = S_DONE;
          tmo_hit = 1'b1;
        end
      end
      S_TX_HOLD: begin
        if (cnt_q == HOLD_END) state_n = S_TX_WAIT_NACK;
      end
      S_TX_WAIT_NACK: begin
        if (!ack_s) begin
          if (!last_bit)
            state_n = S_TX_SETUP;
          else if (words_q == 2'd0)
            state_n = S_WAIT_CMPL;
          else
            state_n = rx_go ? S_RX_WAIT_ACK : S_RX_STALL;
        end else if (tmo_end) begin
          state_n = S_DONE;
          tmo_hit = 1'b1;
        end
      end
      S_RX_WAIT_ACK: begin
        if (ack_s) begin
          state_n = S_RX_HOLD;
        end else if (tmo_end) begin
          state_n = S_DONE;
          tmo_hit = 1'b1;
        end
      end
      S_RX_HOLD: begin
        if (cnt_q == HOLD_END) state_n = S_RX_WAIT_NACK;
      end
      S_RX_WAIT_NACK: begin
        if (!ack_s) begin
          if (!last_bit)
            state_n = S_RX_WAIT_ACK;
          else if (words_q == 2'd1)
            state_n = S_WAIT_CMPL;
          else
            state_n = S_RX_STALL;
        end else if (tmo_end) begin
          state_n = S_DONE;
          tmo_hit = 1'b1;
        end
      end
      // the word just loaded is visible next cycle; re-check here
      S_RX_STALL: begin
        if (rx_go) state_n = S_RX_WAIT_ACK;
      end
      S_WAIT_CMPL: begin
        if (cmpl_s) begin
          state_n = S_DONE;
        end else if (tmo_end) begin
          state_n = S_DONE;
          tmo_hit = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      cnt_q <= '0;
      tmo_q <= '0;
    end else if (state_n != state_q) begin
      cnt_q <= '0;
      tmo_q <= '0;
    end else begin
      if (state_q inside {S_TX_SETUP, S_TX_HOLD, S_RX_HOLD})
        cnt_q <= cnt_q + 1'b1;
      if (wait_st)
        tmo_q <= tmo_q + 1'b1;
    end
  end

  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_q   <= '0;
      words_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      if (accept) begin
        tx_sh   <= {cmd_word, ~^cmd_word};
        words_q <= cmd_resp_words;
        perr_q  <= 1'b0;
        bit_q   <= '0;
      end
      if (tx_shift) begin
        tx_sh <= {tx_sh[15:0], 1'b0};
        bit_q <= last_bit ? 5'd0 : bit_q + 5'd1;
      end
      if (rx_samp)
        rx_sh <= {rx_sh[15:0], dat_s};
      if (rx_step)
        bit_q <= last_bit ? 5'd0 : bit_q + 5'd1;
      if (rx_done) begin
        words_q <= words_q - 2'd1;
        if (!(^rx_sh)) perr_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      rsp_valid      <= 1'b0;
      rsp_word       <= '0;
      rsp_parity_err <= 1'b0;
    end else if (rx_done) begin
      rsp_valid      <= 1'b1;
      rsp_word       <= rx_sh[16:1];
      rsp_parity_err <= !(^rx_sh);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
    if (!csr_aresetn) begin
      done_q <= ST_OK;
    end else if (state_n == S_DONE && state_q != S_DONE) begin
      if (tmo_hit)
        done_q <= ST_TIMEOUT;
      else if (perr_q)
        done_q <= ST_PARITY;
      else
        done_q <= ST_OK;
    end
  end

  assign done_status = done_q;

  always_comb begin
    cmd_ready         = (state_q == S_IDLE);
    done_valid        = (state_q == S_DONE);
    esdi_transfer_req = 1'b0;
    esdi_command_data = 1'b0;
    unique case (1'b1)
      tx_st: begin
        esdi_command_data = tx_sh[16];
        esdi_transfer_req = (state_q == S_TX_WAIT_ACK) ||
                            (state_q == S_TX_HOLD);
      end
      rx_req: begin
        esdi_transfer_req = 1'b1;
      end
      default: begin
        esdi_transfer_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_esdi_serial_cmd_engine.sv
// Directed bench for esdi_serial_cmd_engine with a behavioural
// drive model answering TRANSFER REQ after a fixed delay.
module tb_esdi_serial_cmd_engine;

  localparam int ACK_DLY = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_word = '0;
  logic [1:0]  cmd_resp_words = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_word;
  logic        rsp_parity_err;
  logic        done_valid;
  logic [1:0]  done_status;
  logic        req;
  logic        cd;
  logic        ack = 1'b0;
  logic        sdat = 1'b0;
  logic        cmpl = 1'b1;

  always #5 clk = ~clk;

  esdi_serial_cmd_engine #(
    .DATA_SETUP  (6),
    .ACK_TO_NREQ (6),
    .BIT_TIMEOUT (100)
  ) dut (
    .csr_aclk              (clk),
    .csr_aresetn           (rst_n),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_word              (cmd_word),
    .cmd_resp_words        (cmd_resp_words),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_word              (rsp_word),
    .rsp_parity_err        (rsp_parity_err),
    .done_valid            (done_valid),
    .done_status           (done_status),
    .esdi_transfer_req     (req),
    .esdi_command_data     (cd),
    .esdi_transfer_ack     (ack),
    .esdi_confstat_data    (sdat),
    .esdi_command_complete (cmpl)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // drive model state
  int          nbit = 0;
  int          dly = 0;
  int          hang_bit = 99;
  logic [16:0] rxw [3];
  logic [16:0] tx_bits = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ack = 1'b0;
        dly = 0;
      end else if (req && !ack) begin
        dly++;
        if (dly >= ACK_DLY && nbit != hang_bit) begin
          if (nbit < 17) begin
            tx_bits = {tx_bits[15:0], cd};
          end else begin
            sdat = rxw[(nbit - 17) / 17][16 - ((nbit - 17) % 17)];
          end
          ack = 1'b1;
          dly = 0;
          nbit++;
        end
      end else if (!req && ack) begin
        dly++;
        if (dly >= ACK_DLY) begin
          ack = 1'b0;
          dly = 0;
        end
      end else begin
        dly = 0;
      end
    end
  end

  // monitor: setup time, REQ run length, delivered words
  int          stable = 0;
  int          min_setup = 1000;
  int          run = 0;
  int          last_run = 0;
  logic        prev_cd = 1'b0;
  logic        prev_req = 1'b0;
  logic [16:0] rq [$];

  initial begin
    forever begin
      @(negedge clk);
      if (cd != prev_cd) stable = 0;
      else stable++;
      if (req && !prev_req && nbit < 17 && stable < min_setup)
        min_setup = stable;
      if (req) begin
        run++;
      end else if (prev_req) begin
        last_run = run;
        run = 0;
      end
      if (rsp_valid && rsp_ready)
        rq.push_back({rsp_parity_err, rsp_word});
      prev_cd = cd;
      prev_req = req;
    end
  end

  task automatic send(input logic [15:0] w, input logic [1:0] n);
    nbit = 0;
    tx_bits = '0;
    min_setup = 1000;
    rq.delete();
    @(posedge clk);
    #1;
    cmd_word = w;
    cmd_resp_words = n;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output logic [1:0] st, output logic seen);
    seen = 1'b0;
    st = 2'd3;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done_valid) begin
        seen = 1'b1;
        st = done_status;
        break;
      end
    end
  endtask

  function automatic logic [16:0] qget(input int i);
    if (rq.size() > i) return rq[i];
    return 17'h1ffff;
  endfunction

  logic [1:0] st;
  logic       seen;
  int         hi;
  logic       got;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst req", 32'(req), 0);
    chk("rst cd", 32'(cd), 0);
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst done_valid", 32'(done_valid), 0);
    chk("rst done_status", 32'(done_status), 0);
    chk("rst rsp_word", 32'(rsp_word), 0);
    chk("rst perr", 32'(rsp_parity_err), 0);
    chk("rst cmd_ready", 32'(cmd_ready), 1);
    rst_n = 1'b1;

    // 0x1234, no status words
    send(16'h1234, 2'd0);
    wait_done(st, seen);
    chk("t1 done", 32'(seen), 1);
    chk("t1 status", 32'(st), 0);
    chk("t1 bits", 32'(tx_bits), 32'h02468);
    chk("t1 setup", 32'(min_setup >= 6), 1);
    @(negedge clk);
    chk("t1 ready", 32'(cmd_ready), 1);

    // 0x0000, one word back with good parity
    rxw[0] = {16'hA5A5, 1'b1};
    send(16'h0000, 2'd1);
    wait_done(st, seen);
    chk("t2 status", 32'(st), 0);
    chk("t2 bits", 32'(tx_bits), 32'h00001);
    chk("t2 count", 32'(rq.size()), 1);
    chk("t2 word", 32'(qget(0)), 32'h0A5A5);

    // bad status parity
    rxw[0] = {16'hA5A5, 1'b0};
    send(16'h0000, 2'd1);
    wait_done(st, seen);
    chk("t3 status", 32'(st), 2);
    chk("t3 word", 32'(qget(0)), 32'h1A5A5);
    chk("t3 perr", 32'(rsp_parity_err), 1);

    // drive never acks bit 3
    hang_bit = 3;
    send(16'hFFFF, 2'd0);
    wait_done(st, seen);
    chk("t4 done", 32'(seen), 1);
    chk("t4 status", 32'(st), 1);
    chk("t4 req", 32'(req), 0);
    chk("t4 cd", 32'(cd), 0);
    @(negedge clk);
    chk("t4 ready", 32'(cmd_ready), 1);
    chk("t4 req run", 32'(last_run), 100);
    hang_bit = 99;

    // three words, upstream stalls after the first
    rxw[0] = {16'h1234, 1'b0};
    rxw[1] = {16'hBEEF, 1'b0};
    rxw[2] = {16'h0F0F, 1'b1};
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    send(16'h0003, 2'd3);
    got = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("t5 first", 32'(got), 1);
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req) hi++;
    end
    chk("t5 stall req", 32'(hi), 0);
    chk("t5 held word", 32'(rsp_word), 32'h1234);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_done(st, seen);
    chk("t5 status", 32'(st), 0);
    chk("t5 count", 32'(rq.size()), 3);
    chk("t5 w0", 32'(qget(0)), 32'h01234);
    chk("t5 w1", 32'(qget(1)), 32'h0BEEF);
    chk("t5 w2", 32'(qget(2)), 32'h00F0F);

    // reset while REQ is high on bit 9
    send(16'h5555, 2'd0);
    got = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (nbit == 9 && req && !ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("t6 reach bit9", 32'(got), 1);
    rst_n = 1'b0;
    #1;
    chk("t6 req", 32'(req), 0);
    chk("t6 cd", 32'(cd), 0);
    chk("t6 rsp_word", 32'(rsp_word), 0);
    chk("t6 rsp_valid", 32'(rsp_valid), 0);
    chk("t6 done_valid", 32'(done_valid), 0);
    chk("t6 ready", 32'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_valid) hi++;
    end
    chk("t6 no done", 32'(hi), 0);
    send(16'h00FF, 2'd0);
    wait_done(st, seen);
    chk("t6 done", 32'(seen), 1);
    chk("t6 status", 32'(st), 0);
    chk("t6 bits", 32'(tx_bits), 32'h001FF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
